// File: rtl/calc_mem_arbiter.sv
// calc_mem_arbiter: lockable two-way round-robin arbiter in front of the calculator's single-port memory
package calculator_pkg;
  localparam int ADDR_W = 10;
  localparam int MEM_WORD_SIZE = 32;
endpackage

module calc_mem_arbiter #(
  parameter int ADDR_W = calculator_pkg::ADDR_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     r0_req_i,
  input  logic                     r0_we_i,
  input  logic                     r0_lock_i,
  input  logic [ADDR_W-1:0]        r0_addr_i,
  input  logic [MEM_WORD_SIZE-1:0] r0_wdata_i,
  output logic                     r0_gnt_o,
  output logic                     r0_rvalid_o,
  output logic [MEM_WORD_SIZE-1:0] r0_rdata_o,
  input  logic                     r1_req_i,
  input  logic                     r1_we_i,
  input  logic                     r1_lock_i,
  input  logic [ADDR_W-1:0]        r1_addr_i,
  input  logic [MEM_WORD_SIZE-1:0] r1_wdata_i,
  output logic                     r1_gnt_o,
  output logic                     r1_rvalid_o,
  output logic [MEM_WORD_SIZE-1:0] r1_rdata_o,
  output logic                     mem_read_n_o,
  output logic                     mem_write_n_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i
);
  logic r_last, r_lock, r_owner;
  logic r_s1_v, r_s1_rd, r_s1_id, r_s2_v, r_s2_rd, r_s2_id;
  logic [MEM_WORD_SIZE-1:0] r_rdata0, r_rdata1;
  logic w_hold, w_g0, w_g1, w_any, w_we, w_lk, w_ret0, w_ret1;
  logic [ADDR_W-1:0] w_addr;
  logic [MEM_WORD_SIZE-1:0] w_wdata;
  // A held lock only blocks the other side while its owner keeps requesting
  assign w_hold = r_lock & (r_owner ? r1_req_i : r0_req_i);
  assign w_g0 = ~rst_i & (w_hold ? ~r_owner : r0_req_i & (~r1_req_i | r_last));
  assign w_g1 = ~rst_i & (w_hold ? r_owner : r1_req_i & (~r0_req_i | ~r_last));
  assign w_any = w_g0 | w_g1;
  assign w_we = w_g1 ? r1_we_i : r0_we_i;
  assign w_lk = w_g1 ? r1_lock_i : r0_lock_i;
  assign w_addr = w_g1 ? r1_addr_i : r0_addr_i;
  assign w_wdata = w_g1 ? r1_wdata_i : r0_wdata_i;
  assign r0_gnt_o = w_g0;
  assign r1_gnt_o = w_g1;
  assign w_ret0 = r_s2_v & r_s2_rd & ~r_s2_id;
  assign w_ret1 = r_s2_v & r_s2_rd & r_s2_id;
  assign r0_rvalid_o = w_ret0;
  assign r1_rvalid_o = w_ret1;
  assign r0_rdata_o = w_ret0 ? mem_rdata_i : r_rdata0;
  assign r1_rdata_o = w_ret1 ? mem_rdata_i : r_rdata1;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
      r_lock <= 1'b0;
      r_owner <= 1'b0;
      {r_s1_v, r_s1_rd, r_s1_id, r_s2_v, r_s2_rd, r_s2_id} <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      mem_read_n_o <= 1'b1;
      mem_write_n_o <= 1'b1;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      if (w_any) begin
        r_last <= w_g1;
        r_lock <= w_lk;
        r_owner <= w_g1;
      end else if (r_lock) begin
        r_lock <= 1'b0;
      end
      mem_read_n_o <= ~(w_any & ~w_we);
      mem_write_n_o <= ~(w_any & w_we);
      if (w_any) mem_addr_o <= w_addr;
      if (w_any & w_we) mem_wdata_o <= w_wdata;
      {r_s1_v, r_s1_rd, r_s1_id} <= {w_any, ~w_we, w_g1};
      {r_s2_v, r_s2_rd, r_s2_id} <= {r_s1_v, r_s1_rd, r_s1_id};
      if (w_ret0) r_rdata0 <= mem_rdata_i;
      if (w_ret1) r_rdata1 <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_calc_mem_arbiter.sv
// tb_calc_mem_arbiter: directed stimulus with queued expectations checked by a negedge monitor
module tb_calc_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wd;} cmd_t;
  typedef struct {logic id; logic [DW-1:0] d;} rd_t;
  logic clk = 1'b0, rst;
  logic r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [AW-1:0] r0_addr, r1_addr, mem_addr_o;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata_o, r1_rdata_o, mem_wdata_o, mem_rdata;
  logic r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, mem_read_n_o, mem_write_n_o;
  logic [DW-1:0] mem [16];
  logic gq[$];
  cmd_t mq[$];
  rd_t rq[$];
  logic e_g;
  cmd_t e_c;
  rd_t e_r;
  int checks = 0, errors = 0;

  calc_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_lock_i(r0_lock), .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata), .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o), .r0_rdata_o(r0_rdata_o),
    .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_lock_i(r1_lock), .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata), .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o), .r1_rdata_o(r1_rdata_o),
    .mem_read_n_o(mem_read_n_o), .mem_write_n_o(mem_write_n_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[3] <= 32'h0001_0002;
      mem[4] <= 32'h4444_0004;
      mem[5] <= 32'h5555_0005;
      mem[6] <= 32'h6666_0006;
      mem[10] <= 32'hAAAA_000A;
      mem[11] <= 32'hBBBB_000B;
      mem[12] <= 32'hCCCC_000C;
      mem_rdata <= '0;
    end else begin
      if (!mem_write_n_o) mem[mem_addr_o[3:0]] <= mem_wdata_o;
      if (!mem_read_n_o) mem_rdata <= mem[mem_addr_o[3:0]];
    end
  end

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic q0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic q1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    {r0_req, r0_we, r0_lock, r0_addr, r0_wdata} = {q0, w0, l0, a0, d0};
    {r1_req, r1_we, r1_lock, r1_addr, r1_wdata} = {q1, w1, l1, a1, d1};
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic exp_cmd(input logic g, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    gq.push_back(g);
    mq.push_back('{we, a, d});
  endtask

  always @(negedge clk) begin
    if (rst) chk("gnt_in_reset", 32'({r1_gnt_o, r0_gnt_o}), 32'd0);
    else if (r0_gnt_o || r1_gnt_o) begin
      if (gq.size() == 0) chk("unexpected_gnt", 32'({r1_gnt_o, r0_gnt_o}), 32'd0);
      else begin
        e_g = gq.pop_front();
        chk("gnt", 32'({r1_gnt_o, r0_gnt_o}), e_g ? 32'd2 : 32'd1);
      end
    end
    if (!mem_read_n_o && !mem_write_n_o) chk("strobes_both_low", 32'd1, 32'd0);
    else if (!mem_read_n_o || !mem_write_n_o) begin
      if (mq.size() == 0) chk("unexpected_strobe", 32'({mem_write_n_o, mem_read_n_o}), 32'd3);
      else begin
        e_c = mq.pop_front();
        chk("mem_we", 32'(!mem_write_n_o), 32'(e_c.we));
        chk("mem_addr", 32'(mem_addr_o), 32'(e_c.addr));
        if (e_c.we) chk("mem_wdata", mem_wdata_o, e_c.wd);
      end
    end
    if (r0_rvalid_o && r1_rvalid_o) chk("rvalid_both", 32'd1, 32'd0);
    else if (r0_rvalid_o || r1_rvalid_o) begin
      if (rq.size() == 0) chk("unexpected_rvalid", 32'({r1_rvalid_o, r0_rvalid_o}), 32'd0);
      else begin
        e_r = rq.pop_front();
        chk("rvalid_id", 32'(r1_rvalid_o), 32'(e_r.id));
        chk("rdata", e_r.id ? r1_rdata_o : r0_rdata_o, e_r.d);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_strobes", 32'({mem_read_n_o, mem_write_n_o}), 32'd3);
      chk("idle_addr_wdata", 32'(mem_addr_o) | mem_wdata_o, 32'd0);
      chk("idle_rvalid", 32'({r0_rvalid_o, r1_rvalid_o}), 32'd0);
      chk("idle_rdata", r0_rdata_o | r1_rdata_o, 32'd0);
    end
    step();
    drive(1, 0, 0, 10'h3, '0, 0, 0, 0, '0, '0);
    exp_cmd(0, 0, 10'h3, '0);
    rq.push_back('{1'b0, 32'h0001_0002});
    step();
    idle();
    step();
    step();
    @(negedge clk);
    chk("r0_rdata_hold", r0_rdata_o, 32'h0001_0002);
    chk("r1_rdata_untouched", r1_rdata_o, 32'd0);
    step();
    drive(0, 0, 0, '0, '0, 1, 1, 0, 10'h7, 32'h77);
    exp_cmd(1, 1, 10'h7, 32'h77);
    step();
    drive(1, 0, 0, 10'h5, '0, 1, 0, 0, 10'h6, '0);
    for (int i = 0; i < 6; i++) begin
      exp_cmd(i[0], 0, i[0] ? 10'h6 : 10'h5, '0);
      rq.push_back('{i[0], i[0] ? 32'h6666_0006 : 32'h5555_0005});
      step();
    end
    drive(1, 0, 1, 10'h4, '0, 1, 1, 0, 10'h9, 32'h99);
    exp_cmd(0, 0, 10'h4, '0);
    rq.push_back('{1'b0, 32'h4444_0004});
    step();
    drive(1, 1, 0, 10'h8, 32'h1234_5678, 1, 1, 0, 10'h9, 32'h99);
    exp_cmd(0, 1, 10'h8, 32'h1234_5678);
    step();
    drive(0, 0, 0, '0, '0, 1, 1, 0, 10'h9, 32'h99);
    exp_cmd(1, 1, 10'h9, 32'h99);
    step();
    drive(1, 0, 1, 10'hA, '0, 0, 0, 0, '0, '0);
    exp_cmd(0, 0, 10'hA, '0);
    rq.push_back('{1'b0, 32'hAAAA_000A});
    step();
    drive(0, 0, 0, '0, '0, 1, 0, 0, 10'hB, '0);
    exp_cmd(1, 0, 10'hB, '0);
    rq.push_back('{1'b1, 32'hBBBB_000B});
    step();
    idle();
    @(negedge clk);
    chk("lock_cleared", 32'(dut.r_lock), 32'd0);
    step();
    step();
    drive(0, 0, 0, '0, '0, 1, 0, 0, 10'hC, '0);
    exp_cmd(1, 0, 10'hC, '0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_strobes", 32'({mem_read_n_o, mem_write_n_o}), 32'd3);
    chk("post_reset_rvalid", 32'({r0_rvalid_o, r1_rvalid_o}), 32'd0);
    step();
    drive(1, 0, 0, 10'h3, '0, 1, 0, 0, 10'h4, '0);
    exp_cmd(0, 0, 10'h3, '0);
    rq.push_back('{1'b0, 32'h0001_0002});
    step();
    idle();
    repeat (5) step();
    chk("gq_drained", 32'(gq.size()), 32'd0);
    chk("mq_drained", 32'(mq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/calc_mem_arbiter.md
# calc_mem_arbiter

Two-requester round-robin arbiter that shares the calculator's single-port operand/result memory between the calculator controller (requester 0) and a host loader/readback engine (requester 1). It sits between both masters and the memory macro, registers the selected command onto the memory's active-low strobes, and routes 1-cycle-latency read data back to whichever requester issued the read. A lock input lets a requester hold the port across a read-add-write sequence.

## Interface
- ADDR_W, default calculator_pkg::ADDR_W: memory address width.
- MEM_WORD_SIZE, default calculator_pkg::MEM_WORD_SIZE: memory word width.
- Shared clock and reset ports; requester ports are duplicated with prefixes r0_ and r1_, written rN_ below.
- clk_i  in  1: the single clock; all logic updates on its rising edge.
- rst_i  in  1: synchronous, active-high reset.
- rN_req_i  in  1: requester N presents a command this cycle.
- rN_we_i  in  1: 1 = write, 0 = read; valid with rN_req_i.
- rN_lock_i  in  1: hold ownership after this grant.
- rN_addr_i  in  ADDR_W: command address.
- rN_wdata_i  in  MEM_WORD_SIZE: write data.
- rN_gnt_o  out  1: command accepted this cycle; combinational.
- rN_rvalid_o  out  1: rN_rdata_o holds this requester's read data.
- rN_rdata_o  out  MEM_WORD_SIZE: read data.
- mem_read_n_o  out  1: active-low read strobe.
- mem_write_n_o  out  1: active-low write strobe.
- mem_addr_o  out  ADDR_W: memory address.
- mem_wdata_o  out  MEM_WORD_SIZE: memory write data.
- mem_rdata_i  in  MEM_WORD_SIZE: memory read data, valid 1 cycle after the strobe.

## Operation
- State: last_q, the last granted requester, reset 1 so r0 wins the first tie; lock_q, lock active, reset 0; owner_q, the lock holder; a 2-stage in-flight pipeline of {valid, is_read, id}.
- Arbitration, evaluated every cycle:
  - Locked: if lock_q and the owner requests, the owner is granted and the other requester is blocked.
  - Locked, owner idle: if lock_q and the owner does not request, the lock is released and normal arbitration applies that same cycle.
  - Single request: a lone request is granted.
  - Both requesting: the grant goes to the requester that is not last_q.
- At most one rN_gnt_o is high. A grant is never issued without the matching rN_req_i.
- On grant: last_q <= id, lock_q <= rN_lock_i, owner_q <= id.
- Lock is cleared when the owner is granted with rN_lock_i=0, or when the owner drops its request.
- A requester holds its command stable until granted; there is no queueing inside the block.
- Writes are fire-and-forget; no write acknowledge exists beyond the grant.
- Throughput is one command per cycle, with no bubbles between back-to-back grants.

## Timing
- Grant in cycle N.
- Cycle N+1: mem_* outputs registered from the granted command. Read gives mem_read_n_o=0; write gives mem_write_n_o=0 with mem_addr_o and mem_wdata_o.
- Cycle N+2: for a read, rN_rvalid_o=1 for exactly 1 cycle to the issuing id, with rN_rdata_o = mem_rdata_i.
- rN_rdata_o is registered from mem_rdata_i only when the return belongs to N; otherwise it holds its last value.
- Idle cycles have both strobes high, and address/data hold their previous values.
- Reset values: mem_read_n_o=1, mem_write_n_o=1, mem_addr_o=0, mem_wdata_o=0, rN_rvalid_o=0, rN_rdata_o=0, last_q=1, lock_q=0, pipeline valid bits=0.
- Reset asserted mid-operation: in-flight reads are dropped, so no rvalid follows reset.
- Reset also suppresses rN_gnt_o in the reset cycle.
- Simultaneous read return and new grant: independent; the pipeline handles both in the same cycle.
- The read strobe and write strobe are never both low.

## Test plan
- Reset, then no requests for 5 cycles -> both strobes stay 1, no gnt, no rvalid, all outputs 0.
- r0 reads addr 0x3 (memory holds 0x0001_0002) at cycle 10 -> r0_gnt_o=1 at cycle 10, mem_read_n_o=0 with addr 0x3 at cycle 11, r0_rvalid_o=1 with rdata 0x0001_0002 at cycle 12, r1_rvalid_o stays 0.
- r0 and r1 both request continuously for 6 cycles, no lock -> grants go r0, r1, r0, r1, r0, r1; strobes are low every cycle from the 2nd onward.
- r0 asserts lock with a read at 0x4, then a write at 0x8 with lock=0, while r1 requests throughout -> r0 wins two consecutive grants, then r1 is granted.
- r0 locks, then drops req for one cycle while r1 requests -> r1 is granted in that same cycle, and lock_q clears.
- Reset asserted in the cycle after an r1 read grant -> no r1_rvalid_o ever pulses for that read; strobes are 1 after reset; the first tie after reset goes to r0.
